vedic_mult_seq: RTL and testbench
=================================

Name: vedic_mult_seq

Overview:
Parametrised, iterative Urdhva-Tiryagbhyam multiplier. Successor to the fixed 2x2 combinational multiplier cell.
- Splits WIDTH-bit operands into 2-bit digits.
- Computes one 2x2 digit cross-product per clock and accumulates it, shifted, into a 2*WIDTH-bit product.
- Uses valid/ready handshakes on both sides.
- Sits between the operand capture logic and the binary-to-BCD / seven-segment display path.

Parameters:
WIDTH, 4, operand width in bits; even, >= 2.
DIGITS, WIDTH/2, derived localparam; number of 2-bit digits per operand.
PWIDTH, 2*WIDTH, derived localparam; product width.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  operands a, b presented.
in_ready  output  1  block can accept operands.
a  input  WIDTH  multiplicand.
b  input  WIDTH  multiplier.
out_valid  output  1  product valid.
out_ready  input  1  consumer accepts product.
p  output  PWIDTH  product a*b.
busy  output  1  high in CALC state.

Behaviour:
- Reset (asynchronous, rst=1): state=IDLE, in_ready=1, out_valid=0, busy=0, p=0, digit indices i=j=0, accumulator=0, operand registers=0.
- FSM states:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch a and b, clear accumulator, set i=j=0, go to CALC.
  - CALC: busy=1, in_ready=0. Each cycle: acc += blk(a[2i+1:2i], b[2j+1:2j]) << (2*(i+j)). Then advance j; when j wraps past DIGITS-1, j=0 and i++.
    - After the pair (DIGITS-1, DIGITS-1), go to DONE.
    - p is loaded with the final sum on the same edge.
  - DONE: out_valid=1, p stable. On out_ready=1, go to IDLE and drop out_valid. out_ready=0 holds DONE indefinitely with p unchanged.
- Latency: accept edge to out_valid high = DIGITS*DIGITS+1 cycles (WIDTH=4 gives 5; WIDTH=8 gives 17).
- Throughput: one product per DIGITS*DIGITS+2 cycles with out_ready tied high. No new operand is accepted in CALC or DONE.
- Arithmetic:
  - Unsigned by default.
  - Accumulator is PWIDTH bits and never overflows, since the maximum product is (2^WIDTH-1)^2.
  - Each block product is 4 bits, max 9.
- Boundaries:
  - in_valid while busy is ignored; the source holds it.
  - Operand changes after accept have no effect.
  - a=0 or b=0 still runs the full CALC sequence; no early exit.
  - rst asserted mid-CALC or in DONE aborts immediately to IDLE; no out_valid pulse follows.
  - p holds its last value after DONE→IDLE until the next DONE load.
- WIDTH=2: DIGITS=1, one CALC cycle, latency 2.

Optional Feature:
Macro VEDIC_SIGNED_EN.
- Defined: a and b are two's-complement.
  - On accept, latch magnitudes |a| and |b| as WIDTH-bit unsigned, plus sign = a[MSB]^b[MSB].
  - On the CALC→DONE edge, p = sign ? -acc : acc.
  - -2^(WIDTH-1) is handled correctly: its magnitude fits in WIDTH unsigned bits.
  - Latency is unchanged.
- Undefined: operands are unsigned; there is no sign logic.

Decomposition:
- Shared package vedic_pkg:
  - State enum (IDLE, CALC, DONE).
  - Function clog2 for index widths.
  - Constant BLK_W=2.
- Sub-module vedic_blk_2x2: combinational 2-bit × 2-bit → 4-bit digit product built from half adders. Instantiated once and fed by digit muxes indexed by i and j.

Test Plan:
- WIDTH=4, rst pulse mid-idle, a=15, b=15, out_ready=1 → out_valid 5 cycles after accept, p=225 (8'hE1), in_ready low for the 5 CALC/DONE cycles.
- WIDTH=8, a=255, b=255 → p=65025 after 17 cycles; a=0, b=200 → p=0 after 17 cycles.
- WIDTH=4, a=9, b=6, out_ready=0 for 10 cycles → out_valid stays high and p=54 stable; in_valid with a=3, b=3 ignored until out_ready then accepted, giving p=9.
- WIDTH=8, accept a=100, b=100, assert rst at cycle 6 of CALC → outputs reset immediately, no out_valid; then a=12, b=11 → p=132.
- VEDIC_SIGNED_EN, WIDTH=4: a=-8, b=7 → p=8'hC8 (-56); a=-8, b=-8 → p=64; a=-1, b=1 → p=8'hFF.
- WIDTH=2: exhaustive 16 operand pairs back-to-back → each p=a*b with latency 2.

Source files
------------

// File: rtl/vedic_pkg.sv
// Shared definitions for the iterative Urdhva-Tiryagbhyam multiplier.
// Optional macro VEDIC_SIGNED_EN (consumed by vedic_mult_seq) selects
// two's-complement operands.
package vedic_pkg;

    // Digit width handled by one cross-product cell
    localparam int BLK_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    // Index width helper; never returns less than 1 so a single-digit
    // configuration still gets a legal 1-bit counter.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/vedic_blk_2x2.sv
// 2-bit x 2-bit combinational digit product built from two half adders.
module vedic_blk_2x2 (
    input  logic [1:0] a_i,
    input  logic [1:0] b_i,
    output logic [3:0] p_o
);
    logic pp01, pp10, pp11;
    logic s1, c1, s2, c2;

    assign pp01 = a_i[0] & b_i[1];
    assign pp10 = a_i[1] & b_i[0];
    assign pp11 = a_i[1] & b_i[1];

    // Half adder on the two middle partial products
    assign s1 = pp01 ^ pp10;
    assign c1 = pp01 & pp10;
    // Half adder folding that carry into the top partial product
    assign s2 = pp11 ^ c1;
    assign c2 = pp11 & c1;

    assign p_o = {c2, s2, s1, a_i[0] & b_i[0]};

endmodule

// File: rtl/vedic_mult_seq.sv
// Iterative Urdhva-Tiryagbhyam multiplier: one 2x2 digit cross-product per
// clock, accumulated shifted into a 2*WIDTH-bit product.
// Define VEDIC_SIGNED_EN for two's-complement operands (sign-magnitude
// internally, same latency).
module vedic_mult_seq
    import vedic_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] p,
    output logic               busy
);
    localparam int DIGITS = WIDTH / BLK_W;
    localparam int PWIDTH = 2 * WIDTH;
    localparam int IDX_W  = clog2(DIGITS);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(DIGITS - 1);

    state_e              state_q, state_d;
    logic [WIDTH-1:0]    a_q, a_d, b_q, b_d;
    logic [IDX_W-1:0]    i_q, i_d, j_q, j_d;
    logic [PWIDTH-1:0]   acc_q, acc_d, p_q, p_d;
`ifdef VEDIC_SIGNED_EN
    logic                sign_q, sign_d;
`endif

    logic [WIDTH-1:0]    a_sh, b_sh;
    logic [3:0]          blk_p;
    logic [IDX_W+1:0]    shamt;
    logic [PWIDTH-1:0]   sum;

    // Digit muxes: pick digit i of a and digit j of b
    assign a_sh  = a_q >> {i_q, 1'b0};
    assign b_sh  = b_q >> {j_q, 1'b0};
    assign shamt = {({1'b0, i_q} + {1'b0, j_q}), 1'b0};

    vedic_blk_2x2 u_blk (
        .a_i (a_sh[1:0]),
        .b_i (b_sh[1:0]),
        .p_o (blk_p)
    );

    // Weight the digit product by 4^(i+j) and add to the running sum
    assign sum = acc_q + (PWIDTH'(blk_p) << shamt);

    assign p = p_q;

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            i_q     <= '0;
            j_q     <= '0;
            acc_q   <= '0;
            p_q     <= '0;
`ifdef VEDIC_SIGNED_EN
            sign_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            i_q     <= i_d;
            j_q     <= j_d;
            acc_q   <= acc_d;
            p_q     <= p_d;
`ifdef VEDIC_SIGNED_EN
            sign_q  <= sign_d;
`endif
        end
    end

    // Next-state, digit walk and handshake outputs
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        i_d       = i_q;
        j_d       = j_q;
        acc_d     = acc_q;
        p_d       = p_q;
`ifdef VEDIC_SIGNED_EN
        sign_d    = sign_q;
`endif
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;

        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
`ifdef VEDIC_SIGNED_EN
                    // Magnitudes fit in WIDTH unsigned bits, including -2^(WIDTH-1)
                    a_d    = a[WIDTH-1] ? (~a + 1'b1) : a;
                    b_d    = b[WIDTH-1] ? (~b + 1'b1) : b;
                    sign_d = a[WIDTH-1] ^ b[WIDTH-1];
`else
                    a_d    = a;
                    b_d    = b;
`endif
                    acc_d   = '0;
                    i_d     = '0;
                    j_d     = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                busy  = 1'b1;
                acc_d = sum;
                if (j_q == LAST) begin
                    j_d = '0;
                    if (i_q == LAST) begin
                        state_d = DONE;
`ifdef VEDIC_SIGNED_EN
                        p_d = sign_q ? (~sum + 1'b1) : sum;
`else
                        p_d = sum;
`endif
                    end else begin
                        i_d = i_q + 1'b1;
                    end
                end else begin
                    j_d = j_q + 1'b1;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_vedic_mult_seq.sv
// Directed bench for vedic_mult_seq at WIDTH=2, 4 and 8.
module tb_vedic_mult_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  iv  = '0;
    logic [2:0]  ordy = 3'b111;
    logic [7:0]  av = '0, bv = '0;
    logic [2:0]  ir, ov, bz;
    logic [3:0]  p2;
    logic [7:0]  p4;
    logic [15:0] p8;

    int          tests = 0, fails = 0;
    int          k_sel = 0;
    logic        ir_s, ov_s, bz_s;
    logic [15:0] p_s;

    always #5 clk = ~clk;

    vedic_mult_seq #(.WIDTH(2)) u2 (.clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
        .a(av[1:0]), .b(bv[1:0]), .out_valid(ov[0]), .out_ready(ordy[0]), .p(p2), .busy(bz[0]));
    vedic_mult_seq #(.WIDTH(4)) u4 (.clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
        .a(av[3:0]), .b(bv[3:0]), .out_valid(ov[1]), .out_ready(ordy[1]), .p(p4), .busy(bz[1]));
    vedic_mult_seq #(.WIDTH(8)) u8 (.clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]),
        .a(av), .b(bv), .out_valid(ov[2]), .out_ready(ordy[2]), .p(p8), .busy(bz[2]));

    // Observe the instance currently under test
    always_comb begin
        ir_s = ir[k_sel];
        ov_s = ov[k_sel];
        bz_s = bz[k_sel];
        case (k_sel)
            0:       p_s = {12'b0, p2};
            1:       p_s = {8'b0, p4};
            default: p_s = p8;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start(input int k, input logic [7:0] x, input logic [7:0] y);
        k_sel = k;
        av    = x;
        bv    = y;
        iv[k] = 1'b1;
    endtask

    // Wait (bounded) for out_valid; in_ready/busy must stay low/high meanwhile
    task automatic wait_done(input int k, input string tag, input int exp_lat, input logic [15:0] exp_p);
        int  lat;
        bit  done;
        lat  = 0;
        done = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(posedge clk); #1;
            if (c == 0) begin
                iv[k] = 1'b0;
                av    = ~av;      // operand changes after accept must not matter
                bv    = 8'h5A;
            end
            lat++;
            if (ov_s) done = 1;
            else begin
                chk({tag, "_ir_calc"}, ir_s, 0);
                chk({tag, "_busy"}, bz_s, 1);
            end
        end
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_p"}, p_s, exp_p);
        chk({tag, "_ir_done"}, ir_s, 0);
    endtask

    // One edge with out_ready high: back to IDLE, p held
    task automatic drain(input string tag, input logic [15:0] exp_p);
        @(posedge clk); #1;
        chk({tag, "_ov_idle"}, ov_s, 0);
        chk({tag, "_ir_idle"}, ir_s, 1);
        chk({tag, "_p_hold"}, p_s, exp_p);
    endtask

    initial begin
        // Reset state on all widths
        #12;
        for (int k = 0; k < 3; k++) begin
            k_sel = k; #1;
            chk("rst_ir", ir_s, 1);
            chk("rst_ov", ov_s, 0);
            chk("rst_busy", bz_s, 0);
            chk("rst_p", p_s, 0);
        end
        @(posedge clk); #1; rst = 1'b0;
        // Reset pulse while idle
        @(posedge clk); #1; rst = 1'b1;
        #2; k_sel = 1; #1;
        chk("rst_idle_ir", ir_s, 1);
        rst = 1'b0;
        @(posedge clk); #1;

`ifdef VEDIC_SIGNED_EN
        start(1, 8'h08, 8'h07); wait_done(1, "s_m8x7", 5, 16'h00C8); drain("s_m8x7", 16'h00C8);
        start(1, 8'h08, 8'h08); wait_done(1, "s_m8xm8", 5, 16'h0040); drain("s_m8xm8", 16'h0040);
        start(1, 8'h0F, 8'h01); wait_done(1, "s_m1x1", 5, 16'h00FF); drain("s_m1x1", 16'h00FF);
        start(1, 8'h03, 8'h0E); wait_done(1, "s_3xm2", 5, 16'h00FA); drain("s_3xm2", 16'h00FA);
`else
        // WIDTH=4 full scale
        start(1, 8'd15, 8'd15); wait_done(1, "w4_15x15", 5, 16'd225); drain("w4_15x15", 16'd225);

        // WIDTH=8
        start(2, 8'd255, 8'd255); wait_done(2, "w8_max", 17, 16'd65025); drain("w8_max", 16'd65025);
        start(2, 8'd0, 8'd200);   wait_done(2, "w8_zero", 17, 16'd0);    drain("w8_zero", 16'd0);
        start(2, 8'd37, 8'd201);  wait_done(2, "w8_37x201", 17, 16'd7437); drain("w8_37x201", 16'd7437);

        // WIDTH=4 back-pressure: DONE holds, new in_valid ignored until released
        ordy[1] = 1'b0;
        start(1, 8'd9, 8'd6); wait_done(1, "hold", 5, 16'd54);
        iv[1] = 1'b1; av = 8'd3; bv = 8'd3;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            chk("hold_ov", ov_s, 1);
            chk("hold_p", p_s, 54);
            chk("hold_ir", ir_s, 0);
        end
        ordy[1] = 1'b1;
        @(posedge clk); #1;
        chk("hold_rel_ov", ov_s, 0);
        chk("hold_rel_ir", ir_s, 1);
        wait_done(1, "hold_3x3", 5, 16'd9); drain("hold_3x3", 16'd9);

        // WIDTH=8 reset mid-CALC aborts with no out_valid
        start(2, 8'd100, 8'd100);
        @(posedge clk); #1; iv[2] = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("abort_busy_pre", bz_s, 1);
        rst = 1'b1; #1;
        chk("abort_busy", bz_s, 0);
        chk("abort_ov", ov_s, 0);
        chk("abort_ir", ir_s, 1);
        chk("abort_p", p_s, 0);
        @(posedge clk); #1; rst = 1'b0;
        for (int c = 0; c < 14; c++) begin
            @(posedge clk); #1;
            chk("abort_no_ov", ov_s, 0);
        end
        start(2, 8'd12, 8'd11); wait_done(2, "w8_12x11", 17, 16'd132); drain("w8_12x11", 16'd132);

        // WIDTH=2 exhaustive
        for (int x = 0; x < 4; x++) begin
            for (int y = 0; y < 4; y++) begin
                start(0, 8'(x), 8'(y));
                wait_done(0, "w2", 2, 16'(x * y));
                drain("w2", 16'(x * y));
            end
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
